// File: rtl/stage_sequencer.sv
// Best-of-N match sequencer: timed intro/battle/pause/result stages with per-side
// round scores and a one-cycle round reset pulse on every INTRO entry.
module stage_sequencer #(
  parameter int unsigned MAX_ROUNDS    = 3,
  parameter int unsigned WIN_ROUNDS    = 2,
  parameter int unsigned INTRO_FRAMES  = 90,
  parameter int unsigned RESULT_FRAMES = 120
) (
  input  logic                              Clk,
  input  logic                              Reset_n,
  input  logic                              Fight,
  input  logic                              Pause,
  input  logic                              Restart,
  input  logic                              Player_Dead,
  input  logic                              NPC_Dead,
  output logic                              start_l,
  output logic                              intro_l,
  output logic                              battle_l,
  output logic                              pause_l,
  output logic                              round_end_l,
  output logic                              win_l,
  output logic                              lose_l,
  output logic                              round_rst,
  output logic [$clog2(MAX_ROUNDS+1)-1:0]   round_num,
  output logic [$clog2(MAX_ROUNDS+1)-1:0]   player_score,
  output logic [$clog2(MAX_ROUNDS+1)-1:0]   npc_score,
  output logic [1:0]                        round_result
);

  localparam int unsigned CW   = $clog2(MAX_ROUNDS + 1);
  localparam int unsigned TMAX = (INTRO_FRAMES > RESULT_FRAMES) ? INTRO_FRAMES : RESULT_FRAMES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] INTRO_LOAD  = TW'(INTRO_FRAMES - 1);
  localparam logic [TW-1:0] RESULT_LOAD = TW'(RESULT_FRAMES - 1);
  localparam logic [CW-1:0] MAX_C       = CW'(MAX_ROUNDS);
  localparam logic [CW-1:0] WIN_C       = CW'(WIN_ROUNDS);

  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_INTRO     = 3'd1,
    ST_BATTLE    = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_ROUND_END = 3'd4,
    ST_WIN       = 3'd5,
    ST_LOSE      = 3'd6
  } state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [CW-1:0]  round_q, round_d;
  logic [CW-1:0]  pscore_q, pscore_d;
  logic [CW-1:0]  nscore_q, nscore_d;
  logic [1:0]     result_q, result_d;
  logic           rst_pulse_q, rst_pulse_d;
  logic           fight_q, pause_q;
  logic           fight_e, pause_e;

  assign fight_e = Fight & ~fight_q;
  assign pause_e = Pause & ~pause_q;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAX_C) ? v : v + CW'(1);
  endfunction

  // Next-state and counter updates; Restart is applied last so it overrides all.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    round_d  = round_q;
    pscore_d = pscore_q;
    nscore_d = nscore_q;
    result_d = result_q;

    case (state_q)
      ST_START: begin
        if (fight_e) begin
          state_d  = ST_INTRO;
          timer_d  = INTRO_LOAD;
          pscore_d = '0;
          nscore_d = '0;
          round_d  = CW'(1);
          result_d = 2'b00;
        end
      end
      ST_INTRO: begin
        if (timer_q == '0) state_d = ST_BATTLE;
        else               timer_d = timer_q - TW'(1);
      end
      ST_BATTLE: begin
        if (Player_Dead && NPC_Dead) begin
          state_d  = ST_ROUND_END;
          timer_d  = RESULT_LOAD;
          result_d = 2'b11;
        end else if (NPC_Dead) begin
          state_d  = ST_ROUND_END;
          timer_d  = RESULT_LOAD;
          result_d = 2'b01;
          pscore_d = sat_inc(pscore_q);
        end else if (Player_Dead) begin
          state_d  = ST_ROUND_END;
          timer_d  = RESULT_LOAD;
          result_d = 2'b10;
          nscore_d = sat_inc(nscore_q);
        end else if (pause_e) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_e) state_d = ST_BATTLE;
      end
      ST_ROUND_END: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (pscore_q == WIN_C) begin
          state_d = ST_WIN;
        end else if (nscore_q == WIN_C) begin
          state_d = ST_LOSE;
        end else if (round_q == MAX_C) begin
          state_d = (pscore_q > nscore_q) ? ST_WIN : ST_LOSE;
        end else begin
          state_d = ST_INTRO;
          timer_d = INTRO_LOAD;
          round_d = sat_inc(round_q);
        end
      end
      ST_WIN, ST_LOSE: begin
        if (fight_e) begin
          state_d  = ST_START;
          pscore_d = '0;
          nscore_d = '0;
          round_d  = '0;
        end
      end
      default: state_d = ST_START;
    endcase

    if (Restart) begin
      state_d  = ST_START;
      timer_d  = '0;
      round_d  = '0;
      pscore_d = '0;
      nscore_d = '0;
      result_d = 2'b00;
    end
  end

  assign rst_pulse_d = (state_d == ST_INTRO) && (state_q != ST_INTRO);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_START;
      timer_q     <= '0;
      round_q     <= '0;
      pscore_q    <= '0;
      nscore_q    <= '0;
      result_q    <= 2'b00;
      rst_pulse_q <= 1'b0;
      fight_q     <= 1'b0;
      pause_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      round_q     <= round_d;
      pscore_q    <= pscore_d;
      nscore_q    <= nscore_d;
      result_q    <= result_d;
      rst_pulse_q <= rst_pulse_d;
      fight_q     <= Fight;
      pause_q     <= Pause;
    end
  end

  assign start_l      = (state_q == ST_START);
  assign intro_l      = (state_q == ST_INTRO);
  assign battle_l     = (state_q == ST_BATTLE);
  assign pause_l      = (state_q == ST_PAUSE);
  assign round_end_l  = (state_q == ST_ROUND_END);
  assign win_l        = (state_q == ST_WIN);
  assign lose_l       = (state_q == ST_LOSE);
  assign round_rst    = rst_pulse_q;
  assign round_num    = round_q;
  assign player_score = pscore_q;
  assign npc_score    = nscore_q;
  assign round_result = result_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with INTRO_FRAMES=4, RESULT_FRAMES=3, MAX_ROUNDS=3, WIN_ROUNDS=2.
module tb_stage_sequencer;

  localparam logic [6:0] S_START  = 7'b1000000;
  localparam logic [6:0] S_INTRO  = 7'b0100000;
  localparam logic [6:0] S_BATTLE = 7'b0010000;
  localparam logic [6:0] S_PAUSE  = 7'b0001000;
  localparam logic [6:0] S_RE     = 7'b0000100;
  localparam logic [6:0] S_WIN    = 7'b0000010;
  localparam logic [6:0] S_LOSE   = 7'b0000001;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Fight = 1'b0, Pause = 1'b0, Restart = 1'b0;
  logic       Player_Dead = 1'b0, NPC_Dead = 1'b0;
  logic       start_l, intro_l, battle_l, pause_l, round_end_l, win_l, lose_l;
  logic       round_rst;
  logic [1:0] round_num, player_score, npc_score, round_result;
  logic [6:0] stage;

  int checks = 0;
  int errors = 0;

  stage_sequencer #(
    .MAX_ROUNDS(3), .WIN_ROUNDS(2), .INTRO_FRAMES(4), .RESULT_FRAMES(3)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Fight(Fight), .Pause(Pause), .Restart(Restart),
    .Player_Dead(Player_Dead), .NPC_Dead(NPC_Dead),
    .start_l(start_l), .intro_l(intro_l), .battle_l(battle_l), .pause_l(pause_l),
    .round_end_l(round_end_l), .win_l(win_l), .lose_l(lose_l), .round_rst(round_rst),
    .round_num(round_num), .player_score(player_score), .npc_score(npc_score),
    .round_result(round_result)
  );

  always #5 Clk = ~Clk;

  assign stage = {start_l, intro_l, battle_l, pause_l, round_end_l, win_l, lose_l};

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Fight edge from START, then run the 4 INTRO cycles into BATTLE.
  task automatic start_round_from_start();
    Fight = 1'b1; step(); Fight = 1'b0; step(4);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; step(2);
    Reset_n = 1'b1; step();
    checks++; if (stage !== S_START) begin errors++; $display("FAIL reset_stage got %b want %b", stage, S_START); end
    checks++; if (round_num !== 2'd0) begin errors++; $display("FAIL reset_round got %0d want 0", round_num); end
    checks++; if ({player_score, npc_score, round_result, round_rst} !== 7'd0) begin errors++;
      $display("FAIL reset_scores got %0d/%0d res %b rst %b want 0/0 00 0", player_score, npc_score, round_result, round_rst); end
  endtask

  task automatic test_fight_hold();
    int pulses = 0, intro_cyc = 0;
    Fight = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (round_rst) pulses++;
      if (intro_l) intro_cyc++;
      if (i == 0) begin
        checks++; if (intro_l !== 1'b1 || round_rst !== 1'b1 || round_num !== 2'd1) begin errors++;
          $display("FAIL intro_entry got intro %b rst %b round %0d want 1 1 1", intro_l, round_rst, round_num); end
      end
    end
    Fight = 1'b0;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL round_rst_pulses got %0d want 1", pulses); end
    checks++; if (intro_cyc !== 4) begin errors++; $display("FAIL intro_length got %0d want 4", intro_cyc); end
    checks++; if (stage !== S_BATTLE) begin errors++; $display("FAIL held_fight_stage got %b want %b", stage, S_BATTLE); end
  endtask

  task automatic test_early_win();
    int re_cyc = 0;
    NPC_Dead = 1'b1; step(); NPC_Dead = 1'b0;
    checks++; if (round_end_l !== 1'b1 || player_score !== 2'd1 || round_result !== 2'b01) begin errors++;
      $display("FAIL r1_npc_dead got re %b ps %0d res %b want 1 1 01", round_end_l, player_score, round_result); end
    for (int i = 0; i < 6 && round_end_l; i++) begin re_cyc++; step(); end
    checks++; if (re_cyc !== 3) begin errors++; $display("FAIL result_length got %0d want 3", re_cyc); end
    checks++; if (intro_l !== 1'b1 || round_rst !== 1'b1 || round_num !== 2'd2) begin errors++;
      $display("FAIL r2_intro got intro %b rst %b round %0d want 1 1 2", intro_l, round_rst, round_num); end
    step(4);
    NPC_Dead = 1'b1; step(); NPC_Dead = 1'b0;
    checks++; if (player_score !== 2'd2) begin errors++; $display("FAIL r2_score got %0d want 2", player_score); end
    step(3);
    checks++; if (stage !== S_WIN || round_num !== 2'd2) begin errors++;
      $display("FAIL early_win got %b round %0d want %b round 2", stage, round_num, S_WIN); end
    Fight = 1'b1; step(); Fight = 1'b0;
    checks++; if (stage !== S_START || player_score !== 2'd0 || round_num !== 2'd0) begin errors++;
      $display("FAIL win_to_start got %b ps %0d round %0d want %b 0 0", stage, player_score, round_num, S_START); end
    step();
  endtask

  task automatic test_tie_lose();
    start_round_from_start();
    Player_Dead = 1'b1; NPC_Dead = 1'b1; step(); Player_Dead = 1'b0; NPC_Dead = 1'b0;
    checks++; if (round_result !== 2'b11 || player_score !== 2'd0 || npc_score !== 2'd0) begin errors++;
      $display("FAIL draw got res %b %0d/%0d want 11 0/0", round_result, player_score, npc_score); end
    step(3 + 4);
    NPC_Dead = 1'b1; step(); NPC_Dead = 1'b0;
    step(3 + 4);
    checks++; if (battle_l !== 1'b1 || round_num !== 2'd3) begin errors++;
      $display("FAIL r3_battle got battle %b round %0d want 1 3", battle_l, round_num); end
    Player_Dead = 1'b1; step(); Player_Dead = 1'b0;
    checks++; if (player_score !== 2'd1 || npc_score !== 2'd1 || round_result !== 2'b10) begin errors++;
      $display("FAIL r3_scores got %0d/%0d res %b want 1/1 10", player_score, npc_score, round_result); end
    step(3);
    checks++; if (stage !== S_LOSE || round_num !== 2'd3) begin errors++;
      $display("FAIL tie_lose got %b round %0d want %b round 3", stage, round_num, S_LOSE); end
    Fight = 1'b1; step(); Fight = 1'b0; step();
  endtask

  task automatic test_pause();
    start_round_from_start();
    Pause = 1'b1; step();
    checks++; if (stage !== S_PAUSE) begin errors++; $display("FAIL pause_enter got %b want %b", stage, S_PAUSE); end
    step(2);
    checks++; if (stage !== S_PAUSE) begin errors++; $display("FAIL pause_held got %b want %b", stage, S_PAUSE); end
    Pause = 1'b0; Player_Dead = 1'b1; step(2);
    checks++; if (stage !== S_PAUSE || npc_score !== 2'd0) begin errors++;
      $display("FAIL pause_ignores_dead got %b ns %0d want %b 0", stage, npc_score, S_PAUSE); end
    Pause = 1'b1; step(); Pause = 1'b0;
    checks++; if (stage !== S_BATTLE) begin errors++; $display("FAIL pause_resume got %b want %b", stage, S_BATTLE); end
    step(); Player_Dead = 1'b0;
    checks++; if (stage !== S_RE || npc_score !== 2'd1 || round_result !== 2'b10) begin errors++;
      $display("FAIL resume_dead got %b ns %0d res %b want %b 1 10", stage, npc_score, round_result, S_RE); end
    step(3 + 4);
    NPC_Dead = 1'b1; Pause = 1'b1; step(); NPC_Dead = 1'b0; Pause = 1'b0;
    checks++; if (stage !== S_RE || round_result !== 2'b01 || player_score !== 2'd1) begin errors++;
      $display("FAIL dead_beats_pause got %b res %b ps %0d want %b 01 1", stage, round_result, player_score, S_RE); end
  endtask

  task automatic test_restart();
    step();
    Restart = 1'b1; step(); Restart = 1'b0;
    checks++; if (stage !== S_START || player_score !== 2'd0 || npc_score !== 2'd0 || round_num !== 2'd0 || round_result !== 2'b00) begin
      errors++; $display("FAIL restart got %b %0d/%0d round %0d res %b want %b 0/0 0 00",
                          stage, player_score, npc_score, round_num, round_result, S_START); end
    step();
  endtask

  task automatic test_async_reset();
    start_round_from_start();
    #2 Reset_n = 1'b0; #1;
    checks++; if (stage !== S_START || round_num !== 2'd0) begin errors++;
      $display("FAIL async_reset got %b round %0d want %b 0", stage, round_num, S_START); end
    #1 Reset_n = 1'b1; step();
    checks++; if (stage !== S_START) begin errors++; $display("FAIL after_reset got %b want %b", stage, S_START); end
  endtask

  initial begin
    test_reset();
    test_fight_hold();
    test_early_win();
    test_tie_lose();
    test_pause();
    test_restart();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
